data_bus_responder: RTL and testbench

Responder end of the CPU data bus. Decodes each bus access into a word-addressed data RAM or a small memory-mapped I/O window holding a free-running cycle counter, an optional countdown timer and an output FIFO. The FIFO is drained by an external consumer through a valid/ready handshake. The block sits beside the CPU and meets its single-cycle timing: read data for the current address in the same cycle, writes committed at the rising edge.

---
 rtl/data_bus_responder_pkg.sv | 29 ++
 rtl/data_bus_out_fifo.sv | 56 +++++
 rtl/data_bus_responder.sv | 145 ++++++++++++++
 tb/tb_data_bus_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_responder_pkg.sv
// Shared constants for the data bus responder: I/O window offsets, STATUS bit
// layout and region select. CPU-side headers mirror these values.
package data_bus_responder_pkg;

   localparam logic [3:0] OFS_CYCLE  = 4'h0;
   localparam logic [3:0] OFS_TIMER  = 4'h4;
   localparam logic [3:0] OFS_FIFO   = 4'h8;
   localparam logic [3:0] OFS_STATUS = 4'hC;

   // The I/O window decodes only address bits [3:2].
   typedef enum logic [1:0] {
      IO_CYCLE  = OFS_CYCLE[3:2],
      IO_TIMER  = OFS_TIMER[3:2],
      IO_FIFO   = OFS_FIFO[3:2],
      IO_STATUS = OFS_STATUS[3:2]
   } io_reg_e;

   localparam int unsigned ST_EMPTY       = 0;
   localparam int unsigned ST_FULL        = 1;
   localparam int unsigned ST_OVERFLOW    = 2;
   localparam int unsigned ST_TIMER_FLAG  = 3;
   localparam int unsigned ST_COUNT_LSB   = 4;
   localparam int unsigned ST_COUNT_WIDTH = 5;

   // Value of the top byte-address bit selecting each region.
   localparam logic REGION_RAM = 1'b0;
   localparam logic REGION_IO  = 1'b1;

endpackage

// File: rtl/data_bus_out_fifo.sv
// Output FIFO for the data bus responder. Head word reads 0 while empty;
// a pop frees a slot for a push in the same cycle even when full.
module data_bus_out_fifo #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned DATA_WIDTH  = 32,
   localparam int unsigned COUNT_WIDTH = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [DATA_WIDTH-1:0]  push_data,
   output logic                   full,
   input  logic                   pop,
   output logic [DATA_WIDTH-1:0]  head,
   output logic                   empty,
   output logic [COUNT_WIDTH-1:0] count
);

   localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   logic [PTR_WIDTH-1:0]   wr_ptr;
   logic [PTR_WIDTH-1:0]   rd_ptr;
   logic [COUNT_WIDTH-1:0] occupancy;
   logic                   pop_fire;
   logic                   push_fire;

   assign empty     = (occupancy == '0);
   assign full      = (occupancy == COUNT_WIDTH'(DEPTH));
   assign count     = occupancy;
   assign head      = empty ? '0 : mem[rd_ptr];
   assign pop_fire  = pop & ~empty;
   assign push_fire = push & (~full | pop_fire);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
      end else begin
         if (push_fire) wr_ptr <= wr_ptr + 1'b1;
         if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_fire, pop_fire})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_fire) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/data_bus_responder.sv
// CPU data bus responder: word RAM plus I/O window (CYCLE, TIMER, FIFO, STATUS).
// Define DATA_BUS_RESPONDER_TIMER_EN to build the countdown timer and timerFlag.
module data_bus_responder
   import data_bus_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RAM_WORDS  = 1024,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] busAddr,
   input  logic [DATA_WIDTH-1:0] busWrData,
   input  logic                  busWrEnable,
   output logic [DATA_WIDTH-1:0] busRdData,
   output logic [DATA_WIDTH-1:0] outData,
   output logic                  outValid,
   input  logic                  outReady
);

   localparam int unsigned WORD_ADDR_WIDTH = ADDR_WIDTH - 2;
   localparam int unsigned RAM_IDX_WIDTH   = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam int unsigned COUNT_WIDTH     = $clog2(FIFO_DEPTH) + 1;

   logic                       ram_sel;
   logic                       io_sel;
   io_reg_e                    io_reg;
   logic [WORD_ADDR_WIDTH-1:0] word_addr;
   logic [RAM_IDX_WIDTH-1:0]   ram_idx;
   logic                       ram_wr;
   logic                       io_wr;
   logic                       status_wr;
   logic                       unused_addr_bits;

   logic [DATA_WIDTH-1:0]      ram [RAM_WORDS];
   logic [31:0]                cycle_count;
   logic [31:0]                timer_value;
   logic                       timer_flag;
   logic                       overflow;
   logic                       overflow_set;

   logic                       fifo_push;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic [COUNT_WIDTH-1:0]     fifo_count;
   logic [DATA_WIDTH-1:0]      fifo_head;
   logic [DATA_WIDTH-1:0]      status_word;

   assign ram_sel          = (busAddr[ADDR_WIDTH-1] == REGION_RAM);
   assign io_sel           = (busAddr[ADDR_WIDTH-1] == REGION_IO);
   assign io_reg           = io_reg_e'(busAddr[3:2]);
   assign word_addr        = busAddr[ADDR_WIDTH-2:2];
   assign ram_idx          = RAM_IDX_WIDTH'(word_addr % WORD_ADDR_WIDTH'(RAM_WORDS));
   assign unused_addr_bits = ^busAddr[1:0];

   assign ram_wr    = busWrEnable & ram_sel;
   assign io_wr     = busWrEnable & io_sel;
   assign fifo_push = io_wr & (io_reg == IO_FIFO);
   assign status_wr = io_wr & (io_reg == IO_STATUS);

   always_ff @(posedge clk) begin
      if (ram_wr) ram[ram_idx] <= busWrData;
   end

   always_ff @(posedge clk) begin
      if (rst) cycle_count <= '0;
      else     cycle_count <= cycle_count + 32'd1;
   end

`ifdef DATA_BUS_RESPONDER_TIMER_EN
   logic timer_expire;

   // Expiry is judged on the pre-edge count, so a same-cycle reload still flags.
   assign timer_expire = (timer_value == 32'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         timer_value <= '0;
         timer_flag  <= 1'b0;
      end else begin
         if (io_wr && io_reg == IO_TIMER) timer_value <= 32'(busWrData);
         else if (timer_value != '0)      timer_value <= timer_value - 32'd1;

         if (timer_expire)                          timer_flag <= 1'b1;
         else if (status_wr && busWrData[ST_TIMER_FLAG]) timer_flag <= 1'b0;
      end
   end
`else
   assign timer_value = '0;
   assign timer_flag  = 1'b0;
`endif

   // A full FIFO only drops the push when the consumer is not draining this cycle.
   assign overflow_set = fifo_push & fifo_full & ~(outValid & outReady);

   always_ff @(posedge clk) begin
      if (rst)                                    overflow <= 1'b0;
      else if (overflow_set)                      overflow <= 1'b1;
      else if (status_wr && busWrData[ST_OVERFLOW]) overflow <= 1'b0;
   end

   data_bus_out_fifo #(
      .DEPTH      (FIFO_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (busWrData),
      .full      (fifo_full),
      .pop       (outReady),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign outValid = ~fifo_empty;
   assign outData  = fifo_head;

   always_comb begin
      status_word                                       = '0;
      status_word[ST_EMPTY]                             = fifo_empty;
      status_word[ST_FULL]                              = fifo_full;
      status_word[ST_OVERFLOW]                          = overflow;
      status_word[ST_TIMER_FLAG]                        = timer_flag;
      status_word[ST_COUNT_LSB +: ST_COUNT_WIDTH]       = ST_COUNT_WIDTH'(fifo_count);
   end

   always_comb begin
      busRdData = '0;
      if (ram_sel) begin
         busRdData = ram[ram_idx];
      end else begin
         case (io_reg)
            IO_CYCLE:  busRdData = DATA_WIDTH'(cycle_count);
            IO_TIMER:  busRdData = DATA_WIDTH'(timer_value);
            IO_FIFO:   busRdData = fifo_head;
            IO_STATUS: busRdData = status_word;
            default:   busRdData = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed scenarios plus random traffic, all
// checked every cycle against a queue/array based reference model.
module tb_data_bus_responder;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 32;
   localparam int unsigned RW = 1024;
   localparam int unsigned FD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] busAddr;
   logic [DW-1:0] busWrData;
   logic          busWrEnable;
   logic [DW-1:0] busRdData;
   logic [DW-1:0] outData;
   logic          outValid;
   logic          outReady;

   always #5 clk = ~clk;

   data_bus_responder #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RAM_WORDS  (RW),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .busAddr     (busAddr),
      .busWrData   (busWrData),
      .busWrEnable (busWrEnable),
      .busRdData   (busRdData),
      .outData     (outData),
      .outValid    (outValid),
      .outReady    (outReady)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] m_ram [RW];
   bit          m_known [RW];
   logic [31:0] m_cycle;
   logic [31:0] m_timer;
   bit          m_tflag;
   bit          m_ovf;
   logic [31:0] m_q [$];
   bit          m_init = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic [31:0] d, input logic we, input logic rdy);
      busAddr     = a;
      busWrData   = d;
      busWrEnable = we;
      outReady    = rdy;
   endtask

   function automatic int ram_index(input logic [15:0] a);
      return int'(a[14:2]) % RW;
   endfunction

   function automatic logic [31:0] model_status();
      int n = m_q.size();
      return (32'(n) << 4) | (32'(m_tflag) << 3) | (32'(m_ovf) << 2) |
             (32'(n == FD) << 1) | 32'(n == 0);
   endfunction

   task automatic model_read(input logic [15:0] a, output logic [31:0] v, output bit known);
      known = 1'b1;
      v     = '0;
      if (!a[15]) begin
         known = m_known[ram_index(a)];
         v     = m_ram[ram_index(a)];
      end else begin
         case (a[3:2])
            2'd0: v = m_cycle;
`ifdef DATA_BUS_RESPONDER_TIMER_EN
            2'd1: v = m_timer;
`endif
            2'd2: v = (m_q.size() > 0) ? m_q[0] : 32'd0;
            2'd3: v = model_status();
            default: v = '0;
         endcase
      end
   endtask

   // Applies one rising edge worth of specified behaviour to the model.
   task automatic model_update();
      int   n;
      bit   io, pop, push, ovf_set, tset, wr;
      logic [1:0] r;
      n    = m_q.size();
      io   = busAddr[15];
      r    = busAddr[3:2];
      wr   = busWrEnable;
      if (rst) begin
         m_cycle = '0;
         m_timer = '0;
         m_tflag = 1'b0;
         m_ovf   = 1'b0;
         m_q.delete();
         m_init  = 1'b1;
      end else begin
         pop     = (n > 0) && outReady;
         push    = wr && io && (r == 2'd2);
         ovf_set = push && (n == FD) && !pop;
         if (pop) void'(m_q.pop_front());
         if (push && ((n < FD) || pop)) m_q.push_back(busWrData);
         if (ovf_set) m_ovf = 1'b1;
         else if (wr && io && r == 2'd3 && busWrData[2]) m_ovf = 1'b0;
`ifdef DATA_BUS_RESPONDER_TIMER_EN
         tset = (m_timer == 32'd1);
         if (wr && io && r == 2'd1) m_timer = busWrData;
         else if (m_timer != 0)     m_timer = m_timer - 1;
         if (tset) m_tflag = 1'b1;
         else if (wr && io && r == 2'd3 && busWrData[3]) m_tflag = 1'b0;
`else
         tset = 1'b0;
`endif
         m_cycle = m_cycle + 32'd1;
      end
      if (wr && !io) begin
         m_ram[ram_index(busAddr)]   = busWrData;
         m_known[ram_index(busAddr)] = 1'b1;
      end
   endtask

   // Inputs are set just after a falling edge; checks, then one rising edge.
   task automatic tick();
      logic [31:0] ev;
      bit          kn;
      #1;
      if (m_init) begin
         model_read(busAddr, ev, kn);
         if (kn) check_eq("rd", busRdData, ev);
         check_eq("valid", 32'(outValid), 32'(m_q.size() > 0));
         check_eq("head", outData, (m_q.size() > 0) ? m_q[0] : 32'd0);
      end
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drive(16'h0000, '0, 1'b0, 1'b0);
      @(negedge clk);
      repeat (3) tick();

      // Cycle counter after reset release
      rst = 1'b0;
      drive(16'h8000, '0, 1'b0, 1'b0);
      #1 check_eq("cycle0", busRdData, 32'd0);
      repeat (5) tick();
      #1 check_eq("cycle5", busRdData, 32'd5);

      // RAM store/load with byte-offset bits ignored
      drive(16'h0010, 32'hDEADBEEF, 1'b1, 1'b0); tick();
      drive(16'h0014, 32'h12345678, 1'b1, 1'b0); tick();
      drive(16'h0010, '0, 1'b0, 1'b0);
      #1 check_eq("ram_10", busRdData, 32'hDEADBEEF);
      tick();
      drive(16'h0013, '0, 1'b0, 1'b0);
      #1 check_eq("ram_13", busRdData, 32'hDEADBEEF);
      tick();
      drive(16'h0014, '0, 1'b0, 1'b0);
      #1 check_eq("ram_14", busRdData, 32'h12345678);
      tick();

      // Cycle counter wrap
      drive(16'h8000, '0, 1'b0, 1'b0);
      force dut.cycle_count = 32'hFFFF_FFFE;
      m_cycle = 32'hFFFF_FFFE;
      #1 release dut.cycle_count;
      tick();
      tick();
      #1 check_eq("cycle_wrap", busRdData, 32'd0);
      tick();

      // Overflow: five pushes into four entries with no consumer
      for (int i = 0; i < 5; i++) begin
         drive(16'h8008, 32'hA0 + 32'(i), 1'b1, 1'b0);
         tick();
      end
      drive(16'h800C, '0, 1'b0, 1'b0);
      #1 check_eq("st_full_ovf", busRdData, 32'h46);
      check_eq("head_first", outData, 32'hA0);
      tick();
      drive(16'h800C, 32'h4, 1'b1, 1'b0); tick();
      drive(16'h800C, '0, 1'b0, 1'b0);
      #1 check_eq("st_ovf_clr", busRdData, 32'h42);
      tick();

      // Full with simultaneous pop and push: no overflow
      drive(16'h8008, 32'hB0, 1'b1, 1'b1); tick();
      drive(16'h800C, '0, 1'b0, 1'b0);
      #1 check_eq("st_push_pop", busRdData, 32'h42);
      tick();
      drive(16'h8008, '0, 1'b0, 1'b1);
      repeat (4) tick();
      drive(16'h800C, '0, 1'b0, 1'b0);
      #1 check_eq("st_drained", busRdData, 32'h01);
      tick();

`ifdef DATA_BUS_RESPONDER_TIMER_EN
      drive(16'h8004, 32'd3, 1'b1, 1'b0); tick();
      drive(16'h800C, '0, 1'b0, 1'b0);
      tick();
      tick();
      #1 check_eq("tflag_early", busRdData, 32'h01);
      tick();
      #1 check_eq("tflag_set", busRdData, 32'h09);
      drive(16'h8004, '0, 1'b0, 1'b0);
      #1 check_eq("timer_zero", busRdData, 32'd0);
      tick();
      drive(16'h800C, 32'h8, 1'b1, 1'b0); tick();
      drive(16'h800C, '0, 1'b0, 1'b0);
      #1 check_eq("tflag_clr", busRdData, 32'h01);
      tick();
`else
      drive(16'h8004, 32'd5, 1'b1, 1'b0); tick();
      drive(16'h8004, '0, 1'b0, 1'b0);
      #1 check_eq("timer_off", busRdData, 32'd0);
      tick();
`endif

      // Reset discards queued words
      for (int i = 0; i < 3; i++) begin
         drive(16'h8008, 32'hC0 + 32'(i), 1'b1, 1'b0);
         tick();
      end
      rst = 1'b1;
      drive(16'h800C, '0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      #1 check_eq("rst_valid", 32'(outValid), 32'd0);
      check_eq("rst_status", busRdData, 32'h01);
      drive(16'h8008, 32'hD0, 1'b1, 1'b0); tick();
      drive(16'h800C, '0, 1'b0, 1'b0);
      #1 check_eq("push_valid", 32'(outValid), 32'd1);
      check_eq("push_head", outData, 32'hD0);
      tick();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [15:0] a;
         logic [31:0] d;
         logic        we;
         int unsigned sel;
         rst = ($urandom_range(0, 99) == 0);
         sel = $urandom_range(0, 3);
         a   = 16'($urandom);
         d   = $urandom;
         case (sel)
            0: begin a[15] = 1'b0; a[11:7] = '0; end
            1: a[15] = 1'b1;
            2: begin a[15] = 1'b1; a[3:2] = 2'd2; end
            default: begin a[15] = 1'b1; a[3:2] = 2'd3; end
         endcase
         if (a[15] && a[3:2] == 2'd1) d = 32'($urandom_range(0, 6));
         we = !rst && ($urandom_range(0, 1) == 1);
         drive(a, d, we, $urandom_range(0, 3) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
